// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard receiver:
//   - scan-code prefix bytes (extended / break)
//   - deframer state encoding
//   - key event entry layout {ext, brk, code[7:0]} (10 bits)
//   - odd-parity helper used when closing a frame
// -----------------------------------------------------------------------------
package ps2_pkg;

    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
    localparam int         PS2_EVT_W        = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data_byte, input logic par_bit);
        return ^{data_byte, par_bit};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// -----------------------------------------------------------------------------
// ps2_sync_filter
// Brings one raw asynchronous PS/2 line into the clock domain through a 2-FF
// synchroniser, then glitch-filters it: the filtered output only changes after
// FILTER_LEN consecutive synchronised samples disagree with it.
// Ports:
//   clock   system clock
//   reset   asynchronous active-low reset (filtered output resets to 1)
//   raw_i   raw asynchronous line
//   filt_o  synchronised, filtered line (registered)
// -----------------------------------------------------------------------------
module ps2_sync_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic filt_o
);

    logic [1:0] sync_q;
    logic [7:0] cnt_q;
    logic       filt_q;

    // Synchroniser plus run-length counter of samples that differ from the output.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
            cnt_q  <= 8'd0;
            filt_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            if (sync_q[1] != filt_q) begin
                // The FILTER_LEN-th differing sample flips the output.
                if (cnt_q == 8'(FILTER_LEN - 1)) begin
                    filt_q <= ~filt_q;
                    cnt_q  <= 8'd0;
                end else begin
                    cnt_q  <= cnt_q + 8'd1;
                end
            end else begin
                cnt_q <= 8'd0;
            end
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/ps2_scan_receiver.sv
// -----------------------------------------------------------------------------
// ps2_scan_receiver
// PS/2 keyboard receiver: conditions ps2_clock/ps2_data, deframes 11-bit frames
// (start, 8 data LSB-first, odd parity, stop) with a frame timeout, decodes the
// E0 (extended) and F0 (break) prefixes, and queues key events in a
// first-word-fall-through FIFO.
// Optional build macro: PS2_TYPEMATIC_FILTER_EN drops auto-repeat makes of the
// most recently pushed make until that key is released or another key is made.
// Ports:
//   clock, reset           system clock, asynchronous active-low reset
//   ps2_clock, ps2_data    raw PS/2 lines
//   rd_en                  pop head event (ignored when empty)
//   code_valid             FIFO not empty
//   code/code_break/code_ext  head event fields (0 when empty)
//   fifo_count             entries held, 0..FIFO_DEPTH
//   parity_err/frame_err/overflow  one-cycle error pulses
// -----------------------------------------------------------------------------
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter  int FILTER_LEN     = 8,
    parameter  int TIMEOUT_CYCLES = 50000,
    parameter  int FIFO_DEPTH     = 8,
    localparam int FIFO_AW        = $clog2(FIFO_DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ps2_clock,
    input  logic             ps2_data,
    input  logic             rd_en,
    output logic             code_valid,
    output logic [7:0]       code,
    output logic             code_break,
    output logic             code_ext,
    output logic [FIFO_AW:0] fifo_count,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overflow
);

    localparam int               TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]    TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0] CNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

    // ---------------- input conditioning ----------------
    logic clk_f_s;
    logic dat_f_s;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clock (clock),
        .reset (reset),
        .raw_i (ps2_clock),
        .filt_o(clk_f_s)
    );

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clock (clock),
        .reset (reset),
        .raw_i (ps2_data),
        .filt_o(dat_f_s)
    );

    // ---------------- deframer ----------------
    ps2_state_e  state_q;
    logic        clk_prev_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        par_q;
    logic [7:0]  byte_q;
    logic        byte_done_q;
    logic        parity_err_q;
    logic        frame_err_q;
    logic [TW-1:0] to_cnt_q;
    logic        strobe_s;
    logic        to_hit_s;

    assign strobe_s = clk_prev_q & ~clk_f_s;
    // Timeout fires on the cycle the idle-edge counter would reach TIMEOUT_CYCLES.
    assign to_hit_s = (state_q != IDLE) && !strobe_s && (to_cnt_q == TO_LAST);

    // Frame FSM, edge detector, timeout counter and error pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            clk_prev_q   <= 1'b1;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_q        <= 1'b0;
            byte_q       <= 8'h00;
            byte_done_q  <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            to_cnt_q     <= '0;
        end else begin
            clk_prev_q   <= clk_f_s;
            byte_done_q  <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (strobe_s || (state_q == IDLE)) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + TW'(1);
            end

            if (to_hit_s) begin
                frame_err_q <= 1'b1;
                state_q     <= IDLE;
            end else if (strobe_s) begin
                case (state_q)
                    IDLE: begin
                        if (!dat_f_s) begin
                            state_q   <= DATA;
                            bit_idx_q <= 3'd0;
                        end else begin
                            state_q   <= IDLE;
                        end
                    end
                    DATA: begin
                        shift_q   <= {dat_f_s, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= PARITY;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                    PARITY: begin
                        par_q   <= dat_f_s;
                        state_q <= STOP;
                    end
                    STOP: begin
                        // A bad stop bit outranks a parity failure.
                        if (!dat_f_s) begin
                            frame_err_q <= 1'b1;
                        end else if (!odd_parity_ok(shift_q, par_q)) begin
                            parity_err_q <= 1'b1;
                        end else begin
                            byte_q      <= shift_q;
                            byte_done_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // ---------------- prefix decoder ----------------
    logic       ext_q;
    logic       brk_q;
    logic       err_s;
    logic       push_cand_s;
    logic       rep_s;
    logic       push_req_s;
    ps2_event_t evt_s;

    assign err_s       = parity_err_q | frame_err_q;
    assign push_cand_s = byte_done_q && (byte_q != PS2_EXT_PREFIX) && (byte_q != PS2_BREAK_PREFIX);
    assign evt_s       = {ext_q, brk_q, byte_q};
    assign push_req_s  = push_cand_s && !rep_s;

    // Pending prefix flags; errors abandon any half-built prefix sequence.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (err_s) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (byte_done_q) begin
            if (byte_q == PS2_EXT_PREFIX) begin
                ext_q <= 1'b1;
            end else if (byte_q == PS2_BREAK_PREFIX) begin
                brk_q <= 1'b1;
            end else begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end else begin
            ext_q <= ext_q;
            brk_q <= brk_q;
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0] last_key_q;
    logic       last_vld_q;

    assign rep_s = push_cand_s && !brk_q && last_vld_q && (last_key_q == {ext_q, byte_q});

    // Remember the last make; its own break (or reset) rearms the repeat filter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_key_q <= 9'd0;
            last_vld_q <= 1'b0;
        end else if (push_cand_s && !brk_q) begin
            last_key_q <= {ext_q, byte_q};
            last_vld_q <= 1'b1;
        end else if (push_cand_s && brk_q && (last_key_q == {ext_q, byte_q})) begin
            last_vld_q <= 1'b0;
        end else begin
            last_vld_q <= last_vld_q;
        end
    end
`else
    assign rep_s = 1'b0;
`endif

    // ---------------- event FIFO ----------------
    ps2_event_t         mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic [FIFO_AW:0]   count_d;
    logic               overflow_q;
    logic               pop_s;
    logic               full_s;
    logic               do_push_s;
    logic               ovf_s;
    ps2_event_t         head_s;

    assign pop_s     = rd_en && (count_q != '0);
    assign full_s    = (count_q == CNT_FULL);
    // A pop in the same cycle frees the slot the push needs.
    assign do_push_s = push_req_s && (!full_s || pop_s);
    assign ovf_s     = push_req_s && full_s && !pop_s;
    assign head_s    = mem_q[rd_ptr_q];

    // Next occupancy from the push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({do_push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage, pointers, occupancy and overflow pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= evt_s;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q    <= count_d;
            overflow_q <= ovf_s;
        end
    end

    // Head fields are forced to zero while the queue is empty.
    always_comb begin
        code       = 8'h00;
        code_break = 1'b0;
        code_ext   = 1'b0;
        if (count_q != '0) begin
            code       = head_s.code;
            code_break = head_s.brk;
            code_ext   = head_s.ext;
        end else begin
            code       = 8'h00;
            code_break = 1'b0;
            code_ext   = 1'b0;
        end
    end

    assign code_valid = (count_q != '0);
    assign fifo_count = count_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
module tb_ps2_scan_receiver;

    localparam int FL   = 8;
    localparam int TO   = 300;
    localparam int FD   = 8;
    localparam int HALF = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clock = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic       code_valid;
    logic [7:0] code;
    logic       code_break;
    logic       code_ext;
    logic [3:0] fifo_count;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    int n_par = 0;
    int n_frm = 0;
    int n_ovf = 0;

    ps2_scan_receiver #(
        .FILTER_LEN(FL),
        .TIMEOUT_CYCLES(TO),
        .FIFO_DEPTH(FD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ps2_clock(ps2_clock),
        .ps2_data(ps2_data),
        .rd_en(rd_en),
        .code_valid(code_valid),
        .code(code),
        .code_break(code_break),
        .code_ext(code_ext),
        .fifo_count(fifo_count),
        .parity_err(parity_err),
        .frame_err(frame_err),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clock) begin
        if (parity_err) n_par++;
        if (frame_err)  n_frm++;
        if (overflow)   n_ovf++;
    end

    task automatic drive_bit(input logic b);
        @(posedge clock); #1 ps2_data = b;
        repeat (HALF) @(posedge clock);
        #1 ps2_clock = 1'b0;
        repeat (HALF) @(posedge clock);
        #1 ps2_clock = 1'b1;
    endtask

    // Full frame; v11/v12 are code_valid FL+3 and FL+4 clocks after the stop falling edge.
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop,
                              input logic pop_sync, output logic v11, output logic v12);
        logic [9:0] bits;
        bits = {(~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 10; i++) drive_bit(bits[i]);
        @(posedge clock); #1 ps2_data = stop;
        repeat (HALF) @(posedge clock);
        #1 ps2_clock = 1'b0;
        repeat (FL + 3) @(posedge clock);
        #1 v11 = code_valid;
        if (pop_sync) rd_en = 1'b1;
        @(posedge clock);
        #1 v12 = code_valid;
        rd_en = 1'b0;
        repeat (HALF - FL - 4) @(posedge clock);
        #1 ps2_clock = 1'b1;
        @(posedge clock); #1 ps2_data = 1'b1;
        repeat (HALF) @(posedge clock);
    endtask

    task automatic send(input logic [7:0] b);
        logic a, c;
        send_frame(b, 1'b0, 1'b1, 1'b0, a, c);
    endtask

    task automatic pop1();
        @(posedge clock); #1 rd_en = 1'b1;
        @(posedge clock); #1 rd_en = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        total++;
        if ({code_valid, code_ext, code_break, code, fifo_count, parity_err, frame_err, overflow} !== 17'd0) begin
            bad++; $display("FAIL reset_in outputs=%h exp=0", {code_valid, code_ext, code_break, code, fifo_count, parity_err, frame_err, overflow});
        end
        reset = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        total++;
        if ({code_valid, code_ext, code_break, code, fifo_count, parity_err, frame_err, overflow} !== 17'd0) begin
            bad++; $display("FAIL reset_out outputs=%h exp=0", {code_valid, code_ext, code_break, code, fifo_count, parity_err, frame_err, overflow});
        end
    endtask

    task automatic test_single();
        logic v11, v12;
        int p0, f0;
        p0 = n_par; f0 = n_frm;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, v11, v12);
        total++;
        if (v11 !== 1'b0) begin bad++; $display("FAIL latency_early got=%b exp=0", v11); end
        total++;
        if (v12 !== 1'b1) begin bad++; $display("FAIL latency_valid got=%b exp=1", v12); end
        total++;
        if ({code_ext, code_break, code} !== {1'b0, 1'b0, 8'h1C}) begin
            bad++; $display("FAIL single_head got=%h exp=%h", {code_ext, code_break, code}, {1'b0, 1'b0, 8'h1C});
        end
        total++;
        if (fifo_count !== 4'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", fifo_count); end
        total++;
        if ((n_par - p0) + (n_frm - f0) !== 0) begin bad++; $display("FAIL single_noerr got=%0d exp=0", (n_par - p0) + (n_frm - f0)); end
        pop1();
        total++;
        if (code_valid !== 1'b0) begin bad++; $display("FAIL single_pop got=%b exp=0", code_valid); end
    endtask

    task automatic test_prefix();
        send(8'hF0); send(8'h1C);
        total++;
        if ({fifo_count, code_ext, code_break, code} !== {4'd1, 1'b0, 1'b1, 8'h1C}) begin
            bad++; $display("FAIL break_evt got=%h exp=%h", {fifo_count, code_ext, code_break, code}, {4'd1, 1'b0, 1'b1, 8'h1C});
        end
        pop1();
        send(8'hE0); send(8'hF0); send(8'h75);
        total++;
        if ({fifo_count, code_ext, code_break, code} !== {4'd1, 1'b1, 1'b1, 8'h75}) begin
            bad++; $display("FAIL ext_break_evt got=%h exp=%h", {fifo_count, code_ext, code_break, code}, {4'd1, 1'b1, 1'b1, 8'h75});
        end
        pop1();
        send(8'hE0); send(8'hF0);
        total++;
        if (fifo_count !== 4'd0) begin bad++; $display("FAIL prefix_only_count got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_errors();
        logic a, c;
        int p0, f0;
        p0 = n_par; f0 = n_frm;
        send_frame(8'h29, 1'b1, 1'b1, 1'b0, a, c);
        total++;
        if ({n_par - p0, n_frm - f0} !== {32'd1, 32'd0}) begin
            bad++; $display("FAIL parity_err par=%0d frm=%0d exp par=1 frm=0", n_par - p0, n_frm - f0);
        end
        send(8'hE0);
        p0 = n_par; f0 = n_frm;
        send_frame(8'h29, 1'b0, 1'b0, 1'b0, a, c);
        total++;
        if ({n_par - p0, n_frm - f0} !== {32'd0, 32'd1}) begin
            bad++; $display("FAIL stop_err par=%0d frm=%0d exp par=0 frm=1", n_par - p0, n_frm - f0);
        end
        total++;
        if (fifo_count !== 4'd0) begin bad++; $display("FAIL err_no_event got=%0d exp=0", fifo_count); end
        send(8'h29);
        total++;
        if ({fifo_count, code_ext, code_break, code} !== {4'd1, 1'b0, 1'b0, 8'h29}) begin
            bad++; $display("FAIL after_err_evt got=%h exp=%h", {fifo_count, code_ext, code_break, code}, {4'd1, 1'b0, 1'b0, 8'h29});
        end
        pop1();
    endtask

    task automatic test_timeout();
        int f0;
        send(8'hE0);
        f0 = n_frm;
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
        repeat (TO + 60) @(posedge clock);
        #1;
        total++;
        if (n_frm - f0 !== 1) begin bad++; $display("FAIL timeout_frm got=%0d exp=1", n_frm - f0); end
        send(8'h1C);
        total++;
        if ({fifo_count, code_ext, code_break, code} !== {4'd1, 1'b0, 1'b0, 8'h1C}) begin
            bad++; $display("FAIL after_timeout_evt got=%h exp=%h", {fifo_count, code_ext, code_break, code}, {4'd1, 1'b0, 1'b0, 8'h1C});
        end
        pop1();
    endtask

    task automatic test_overflow();
        logic a, c;
        int o0;
        logic [7:0] exp;
        o0 = n_ovf;
        for (int i = 1; i <= 10; i++) send(8'(i));
        total++;
        if ({fifo_count, code} !== {4'd8, 8'h01}) begin
            bad++; $display("FAIL ovf_full got=%h exp=%h", {fifo_count, code}, {4'd8, 8'h01});
        end
        total++;
        if (n_ovf - o0 !== 2) begin bad++; $display("FAIL ovf_pulses got=%0d exp=2", n_ovf - o0); end
        send_frame(8'h0B, 1'b0, 1'b1, 1'b1, a, c);
        total++;
        if ({fifo_count, code} !== {4'd8, 8'h02} || n_ovf - o0 !== 2) begin
            bad++; $display("FAIL push_pop_full got=%h ovf=%0d exp=%h ovf=2", {fifo_count, code}, n_ovf - o0, {4'd8, 8'h02});
        end
        for (int i = 0; i < 8; i++) begin
            exp = (i < 7) ? 8'(i + 2) : 8'h0B;
            total++;
            if ({code_valid, code} !== {1'b1, exp}) begin
                bad++; $display("FAIL drain_%0d got=%h exp=%h", i, {code_valid, code}, {1'b1, exp});
            end
            pop1();
        end
        total++;
        if (fifo_count !== 4'd0) begin bad++; $display("FAIL drain_empty got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_glitch();
        int p0, f0;
        p0 = n_par; f0 = n_frm;
        ps2_data = 1'b0;
        repeat (30) @(posedge clock);
        #1 ps2_clock = 1'b0;
        repeat (2) @(posedge clock);
        #1 ps2_clock = 1'b1;
        repeat (30) @(posedge clock);
        #1 ps2_data = 1'b1;
        repeat (30) @(posedge clock);
        send(8'h1C);
        total++;
        if ({fifo_count, code_ext, code_break, code} !== {4'd1, 1'b0, 1'b0, 8'h1C}) begin
            bad++; $display("FAIL glitch_evt got=%h exp=%h", {fifo_count, code_ext, code_break, code}, {4'd1, 1'b0, 1'b0, 8'h1C});
        end
        total++;
        if ((n_par - p0) + (n_frm - f0) !== 0) begin bad++; $display("FAIL glitch_noerr got=%0d exp=0", (n_par - p0) + (n_frm - f0)); end
        pop1();
    endtask

    task automatic test_midframe_reset();
        send(8'h33);
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1);
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock); #1;
        total++;
        if ({code_valid, fifo_count} !== 5'd0) begin
            bad++; $display("FAIL midreset_clear got=%h exp=0", {code_valid, fifo_count});
        end
        reset = 1'b1;
        repeat (5) @(posedge clock);
        send(8'h1C);
        total++;
        if ({fifo_count, code_ext, code_break, code} !== {4'd1, 1'b0, 1'b0, 8'h1C}) begin
            bad++; $display("FAIL midreset_evt got=%h exp=%h", {fifo_count, code_ext, code_break, code}, {4'd1, 1'b0, 1'b0, 8'h1C});
        end
        pop1();
    endtask

    task automatic test_typematic();
        int n_exp;
`ifdef PS2_TYPEMATIC_FILTER_EN
        n_exp = 1;
`else
        n_exp = 3;
`endif
        send(8'h22); pop1();
        send(8'h1C); send(8'h1C); send(8'h1C);
        total++;
        if ({fifo_count, code} !== {4'(n_exp), 8'h1C}) begin
            bad++; $display("FAIL repeat_makes got=%h exp=%h", {fifo_count, code}, {4'(n_exp), 8'h1C});
        end
        for (int i = 0; i < n_exp; i++) pop1();
        send(8'hF0); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
        total++;
        if (fifo_count !== 4'd4) begin bad++; $display("FAIL rearm_count got=%0d exp=4", fifo_count); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({code_break, code} !== {(i % 2 == 0), 8'h1C}) begin
                bad++; $display("FAIL rearm_evt_%0d got=%h exp=%h", i, {code_break, code}, {(i % 2 == 0), 8'h1C});
            end
            pop1();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_prefix();
        test_errors();
        test_timeout();
        test_overflow();
        test_glitch();
        test_midframe_reset();
        test_typematic();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
